// File: rtl/accum_xcel_pkg.sv
// Shared types and widths for the accumulator accelerator launch controller.
package accum_xcel_pkg;

    localparam int unsigned SIZE_W   = 14;
    localparam int unsigned RESULT_W = 32;
    localparam int unsigned COUNT_W  = 16;
    localparam int unsigned SW_W     = 5;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_e;

endpackage

// File: rtl/accum_xcel_launch_if.sv
// Start/size request and result handshake between the launch controller and the accelerator.
interface accum_xcel_launch_if;
    import accum_xcel_pkg::*;

    logic                xcel_go;
    logic [SIZE_W-1:0]   xcel_size;
    logic                xcel_result_val;
    logic [RESULT_W-1:0] xcel_result;

    modport master (output xcel_go, output xcel_size, input xcel_result_val, input xcel_result);
    modport slave  (input xcel_go, input xcel_size, output xcel_result_val, output xcel_result);

endinterface

// File: rtl/accum_xcel_launch_button_debounce.sv
// Two-flop synchronizer plus saturating run-length counter for a bouncing push-button.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pressed
);

    localparam int unsigned           CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
            // Saturate so a held button keeps pressed asserted.
            if (!sync2_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign pressed = (cnt_q == CNT_MAX);

endmodule

// File: rtl/accum_xcel_launch.sv
// Launch controller: debounced button starts the accelerator, then holds its result and latency.
module accum_xcel_launch
    import accum_xcel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 button,
    input  logic [SW_W-1:0]      switches,
    accum_xcel_launch_if.master  xcel,
    output logic                 busy,
    output logic                 disp_val,
    output logic [RESULT_W-1:0]  disp_result,
    output logic                 timeout,
    output logic [COUNT_W-1:0]   cycle_count
);

    localparam logic [COUNT_W-1:0] TIMEOUT_LIM = COUNT_W'(TIMEOUT_CYCLES);

    logic                pressed;
    logic                start;
    state_e              state_q, state_d;
    logic                go_q, go_d;
    logic [SIZE_W-1:0]   size_q, size_d;
    logic                busy_q, busy_d;
    logic                disp_val_q, disp_val_d;
    logic [RESULT_W-1:0] disp_result_q, disp_result_d;
    logic                timeout_q, timeout_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                release_q, release_d;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .in      (button),
        .pressed (pressed)
    );

    // A held button only relaunches from DONE after a release has been seen.
    assign start = pressed && ((state_q == IDLE) || ((state_q == DONE) && release_q));

    always_comb begin
        state_d       = state_q;
        go_d          = 1'b0;
        size_d        = size_q;
        busy_d        = busy_q;
        disp_val_d    = disp_val_q;
        disp_result_d = disp_result_q;
        timeout_d     = timeout_q;
        count_d       = count_q;
        release_d     = release_q;

        unique case (state_q)
            IDLE: ;
            LAUNCH: begin
                state_d = WAIT;
                count_d = COUNT_W'(1);
            end
            WAIT: begin
                if (count_q != '1) begin
                    count_d = count_q + COUNT_W'(1);
                end
                // count_q equals the 1-based index of the current WAIT cycle.
                if (xcel.xcel_result_val) begin
                    disp_result_d = xcel.xcel_result;
                    disp_val_d    = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = DONE;
                end else if (count_q >= TIMEOUT_LIM) begin
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (!pressed) begin
                    release_d = 1'b1;
                end
            end
        endcase

        if (start) begin
            state_d    = LAUNCH;
            go_d       = 1'b1;
            busy_d     = 1'b1;
            size_d     = {{(SIZE_W - SW_W){1'b0}}, switches};
            count_d    = '0;
            disp_val_d = 1'b0;
            timeout_d  = 1'b0;
            release_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            go_q          <= 1'b0;
            size_q        <= '0;
            busy_q        <= 1'b0;
            disp_val_q    <= 1'b0;
            disp_result_q <= '0;
            timeout_q     <= 1'b0;
            count_q       <= '0;
            release_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            go_q          <= go_d;
            size_q        <= size_d;
            busy_q        <= busy_d;
            disp_val_q    <= disp_val_d;
            disp_result_q <= disp_result_d;
            timeout_q     <= timeout_d;
            count_q       <= count_d;
            release_q     <= release_d;
        end
    end

    assign xcel.xcel_go   = go_q;
    assign xcel.xcel_size = size_q;
    assign busy           = busy_q;
    assign disp_val       = disp_val_q;
    assign disp_result    = disp_result_q;
    assign timeout        = timeout_q;
    assign cycle_count    = count_q;

endmodule

// File: tb/tb_accum_xcel_launch.sv
// Directed/randomized bench for accum_xcel_launch with a run-outcome reference model.
module tb_accum_xcel_launch;
    import accum_xcel_pkg::*;

    localparam int unsigned DB  = 4;
    localparam int unsigned TO  = 20;
    localparam int          LAT = 2 + DB + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        button;
    logic [4:0]  switches;
    logic        busy;
    logic        disp_val;
    logic [31:0] disp_result;
    logic        timeout;
    logic [15:0] cycle_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_result = 32'd0;
    int          exp_count = 0;

    accum_xcel_launch_if xcel_bus ();

    accum_xcel_launch #(
        .DEBOUNCE_CYCLES (DB),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .button      (button),
        .switches    (switches),
        .xcel        (xcel_bus.master),
        .busy        (busy),
        .disp_val    (disp_val),
        .disp_result (disp_result),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_go"}, 32'(xcel_bus.xcel_go), 32'd0);
        check({tag, "_size"}, 32'(xcel_bus.xcel_size), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_disp_val"}, 32'(disp_val), 32'd0);
        check({tag, "_disp_result"}, disp_result, 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_cycle_count"}, 32'(cycle_count), 32'd0);
    endtask

    // Raise the button and expect exactly one launch LAT edges later; ends in the LAUNCH cycle.
    task automatic press(input logic [4:0] sw);
        int seen = 0;
        switches = sw;
        button   = 1'b1;
        for (int e = 1; e <= 40 && seen == 0; e++) begin
            @(negedge clk);
            if (xcel_bus.xcel_go === 1'b1) seen = e;
        end
        check("press_latency", 32'(seen), 32'(LAT));
        check("launch_size", 32'(xcel_bus.xcel_size), 32'(sw));
        check("launch_busy", 32'(busy), 32'd1);
        check("launch_disp_val_clr", 32'(disp_val), 32'd0);
        check("launch_timeout_clr", 32'(timeout), 32'd0);
        check("launch_count_clr", 32'(cycle_count), 32'd0);
    endtask

    // Return a result in WAIT cycle d (d outside 1..TO means never) and check the outcome.
    task automatic run_wait(input int d, input logic [31:0] r, input logic [4:0] sw);
        logic hit   = (d >= 1 && d <= TO);
        int   limit = hit ? d : int'(TO);
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            xcel_bus.xcel_result_val = 1'b0;
            xcel_bus.xcel_result     = $urandom;
            if (i == 1) begin
                check("go_single_pulse", 32'(xcel_bus.xcel_go), 32'd0);
                switches = 5'($urandom);
            end
            if (i == limit) check("busy_last_wait", 32'(busy), 32'd1);
            if (i == d) begin
                xcel_bus.xcel_result_val = 1'b1;
                xcel_bus.xcel_result     = r;
            end
        end
        @(negedge clk);
        xcel_bus.xcel_result_val = 1'b0;
        if (hit) last_result = r;
        exp_count = limit + 1;
        check("done_disp_val", 32'(disp_val), 32'(hit));
        check("done_disp_result", disp_result, last_result);
        check("done_timeout", 32'(timeout), 32'(!hit));
        check("done_cycle_count", 32'(cycle_count), 32'(exp_count));
        check("done_busy", 32'(busy), 32'd0);
        check("done_size_held", 32'(xcel_bus.xcel_size), 32'(sw));
    endtask

    // Button stays held in DONE; stray result_val must be ignored and nothing relaunches.
    task automatic hold_done();
        int gos = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            xcel_bus.xcel_result_val = (i == 10);
            xcel_bus.xcel_result     = $urandom;
            if (xcel_bus.xcel_go === 1'b1) gos++;
        end
        @(negedge clk);
        xcel_bus.xcel_result_val = 1'b0;
        check("hold_no_relaunch", 32'(gos), 32'd0);
        check("hold_result_kept", disp_result, last_result);
        check("hold_count_kept", 32'(cycle_count), 32'(exp_count));
        check("hold_busy", 32'(busy), 32'd0);
    endtask

    task automatic release_btn();
        button = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int          gos;
        int          d;
        logic [4:0]  sw;
        rst                      = 1'b1;
        button                   = 1'b0;
        switches                 = 5'd0;
        xcel_bus.xcel_result_val = 1'b0;
        xcel_bus.xcel_result     = 32'd0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        press(5'b00101);
        run_wait(10, 32'd15, 5'b00101);
        hold_done();
        release_btn();

        gos = 0;
        for (int k = 0; k < 4; k++) begin
            button = (k % 2 == 0);
            repeat (2) begin
                @(negedge clk);
                if (xcel_bus.xcel_go === 1'b1) gos++;
            end
        end
        repeat (4) begin
            @(negedge clk);
            if (xcel_bus.xcel_go === 1'b1) gos++;
        end
        check("bounce_no_go", 32'(gos), 32'd0);

        press(5'd3);
        run_wait(int'($urandom_range(1, TO - 1)), $urandom, 5'd3);
        hold_done();
        release_btn();

        sw = 5'($urandom);
        press(sw);
        run_wait(0, 32'd0, sw);
        release_btn();

        sw = 5'($urandom);
        press(sw);
        run_wait(int'(TO), $urandom, sw);
        release_btn();

        for (int n = 0; n < 4; n++) begin
            sw = 5'($urandom);
            d  = int'($urandom_range(1, TO + 3));
            press(sw);
            run_wait(d, $urandom, sw);
            release_btn();
        end

        press(5'd9);
        repeat (3) @(negedge clk);
        rst    = 1'b1;
        button = 1'b0;
        @(negedge clk);
        check_reset_values("midrun_reset");
        rst = 1'b0;
        gos = 0;
        for (int i = 0; i < 4; i++) begin
            xcel_bus.xcel_result_val = 1'b1;
            xcel_bus.xcel_result     = $urandom | 32'd1;
            @(negedge clk);
            if (xcel_bus.xcel_go === 1'b1) gos++;
        end
        xcel_bus.xcel_result_val = 1'b0;
        check("late_result_ignored", 32'(disp_val), 32'd0);
        check("late_result_data", disp_result, 32'd0);
        check("late_result_busy", 32'(busy), 32'd0);
        check("late_result_no_go", 32'(gos), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
